// File: rtl/ascensor_pkg.sv
// Shared constants for the elevator display sequencer: BCD codes, status
// priority encoding and the frame FSM state type.
package ascensor_pkg;

  localparam logic [3:0] BCD_WAIT   = 4'd0;
  localparam logic [3:0] BCD_FLOOR1 = 4'd1;
  localparam logic [3:0] BCD_FLOOR2 = 4'd2;
  localparam logic [3:0] BCD_FLOOR3 = 4'd3;
  localparam logic [3:0] BCD_FLOOR4 = 4'd4;
  localparam logic [3:0] BCD_UP     = 4'd5;
  localparam logic [3:0] BCD_OPEN   = 4'd6;
  localparam logic [3:0] BCD_CLOSED = 4'd7;
  localparam logic [3:0] BCD_DOWN   = 4'd8;
  localparam logic [3:0] BCD_TEST   = 4'd8;
  localparam logic [3:0] BCD_MARK   = 4'd9;

  localparam logic [1:0] MOTION_STOP = 2'b00;
  localparam logic [1:0] MOTION_UP   = 2'b01;
  localparam logic [1:0] MOTION_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_STATUS = 2'd0,
    ST_MARK   = 2'd1,
    ST_FLOOR  = 2'd2,
    ST_TEST   = 2'd3
  } state_e;

  // Door-open wins over motion, motion wins over door-closed; reserved
  // motion code 11 falls through as stopped.
  function automatic logic [3:0] status_code(input logic       door_open,
                                             input logic [1:0] motion,
                                             input logic       door_closed);
    if (door_open)                return BCD_OPEN;
    else if (motion == MOTION_UP)   return BCD_UP;
    else if (motion == MOTION_DOWN) return BCD_DOWN;
    else if (door_closed)           return BCD_CLOSED;
    else                            return BCD_WAIT;
  endfunction

  // Out-of-range floors blank to the wait code rather than leaking 0/5..7.
  function automatic logic [3:0] floor_code(input logic [2:0] floor);
    case (floor)
      3'd1:    return BCD_FLOOR1;
      3'd2:    return BCD_FLOOR2;
      3'd3:    return BCD_FLOOR3;
      3'd4:    return BCD_FLOOR4;
      default: return BCD_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Frame counter 0..DWELL-1: clear wins over enable, wraps to 0 after the
// terminal count, done flags the last cycle of a frame.
module dwell_timer #(
  parameter int unsigned DWELL = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == LAST);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = done ? '0 : cnt_q + CW'(1);
  end

  // NOTE: state updates use <= so all flops see pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ascensor_display_seq.sv
// Elevator display sequencer: cycles status / floor-marker / floor frames on a
// single BCD digit, with restart on status change and a lamp-test override.
module ascensor_display_seq
  import ascensor_pkg::*;
#(
  parameter int unsigned DWELL = 25000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] FLOOR,
  input  logic [1:0] MOTION,
  input  logic       DOOR_OPEN,
  input  logic       DOOR_CLOSED,
  input  logic       LAMP_TEST,
  output logic [3:0] BCD,
  output logic       FRAME_START
);

  logic [2:0] floor_q;
  logic [1:0] motion_q;
  logic       door_open_q;
  logic       door_closed_q;
  logic       lamp_q;

  logic [3:0] status_now;
  logic [3:0] prev_status_q;

  state_e     state_q, state_d;
  logic [3:0] bcd_q, bcd_d;
  logic       frame_start_q, frame_start_d;

  logic       tmr_clear;
  logic       tmr_enable;
  logic       tmr_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      floor_q       <= '0;
      motion_q      <= '0;
      door_open_q   <= 1'b0;
      door_closed_q <= 1'b0;
      lamp_q        <= 1'b0;
    end else begin
      floor_q       <= FLOOR;
      motion_q      <= MOTION;
      door_open_q   <= DOOR_OPEN;
      door_closed_q <= DOOR_CLOSED;
      lamp_q        <= LAMP_TEST;
    end
  end

  assign status_now = status_code(door_open_q, motion_q, door_closed_q);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .done   (tmr_done)
  );

  // BCD is computed from the next state so the code and its frame pulse
  // land on the same edge as the state transition.
  always_comb begin
    state_d       = state_q;
    tmr_clear     = 1'b0;
    tmr_enable    = 1'b0;
    frame_start_d = 1'b0;
    bcd_d         = BCD_WAIT;

    if (lamp_q) begin
      state_d   = ST_TEST;
      tmr_clear = 1'b1;
    end else if (state_q == ST_TEST || status_now != prev_status_q) begin
      state_d       = ST_STATUS;
      tmr_clear     = 1'b1;
      frame_start_d = 1'b1;
    end else if (tmr_done) begin
      case (state_q)
        ST_STATUS: state_d = ST_MARK;
        ST_MARK:   state_d = ST_FLOOR;
        default:   state_d = ST_STATUS;
      endcase
      tmr_clear     = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      tmr_enable = 1'b1;
    end

    case (state_d)
      ST_STATUS: bcd_d = status_now;
      ST_MARK:   bcd_d = BCD_MARK;
      ST_FLOOR:  bcd_d = floor_code(floor_q);
      ST_TEST:   bcd_d = BCD_TEST;
      default:   bcd_d = BCD_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_STATUS;
      prev_status_q <= BCD_WAIT;
      bcd_q         <= BCD_WAIT;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_status_q <= status_now;
      bcd_q         <= bcd_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign BCD         = bcd_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: doc/ascensor_display_seq.md
ASCENSOR_DISPLAY_SEQ -- requirements
Module: ascensor_display_seq

Interface
REQ-001 SHALL have parameter: DWELL, 25000000, clock cycles each display frame is held (legal range 2..2^26).
REQ-002 SHALL have port: CLK  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: FLOOR  input  3  current cabin floor, legal 1..4.
REQ-005 SHALL have port: MOTION  input  2  00 stopped, 01 going up, 10 going down, 11 reserved (treated as stopped).
REQ-006 SHALL have port: DOOR_OPEN  input  1  door fully open.
REQ-007 SHALL have port: DOOR_CLOSED  input  1  door fully closed and locked.
REQ-008 SHALL have port: LAMP_TEST  input  1  level, forces all-segments code.
REQ-009 SHALL have port: BCD  output  4  code for the downstream BCD-to-7-segment decoder.
REQ-010 SHALL have port: FRAME_START  output  1  one-cycle pulse on the first cycle of every new frame.

Function
REQ-011 SHALL encode BCD codes: 0 wait, 1..4 floor, 5 up, 6 open, 7 closed, 8 down / lamp test, 9 floor marker; codes 10..15 SHALL never be driven.
REQ-012 SHALL register FLOOR, MOTION, DOOR_OPEN, DOOR_CLOSED, LAMP_TEST once; BCD SHALL be registered; input change reaches BCD on the second rising edge after it is sampled.
REQ-013 SHALL derive status code with priority: DOOR_OPEN -> 6; else MOTION 01 -> 5; else MOTION 10 -> 8; else DOOR_CLOSED -> 7; else 0.
REQ-014 SHALL run FSM states STATUS, MARK, FLOOR, TEST; STATUS drives status code, MARK drives 9, FLOOR drives registered floor, TEST drives 8.
REQ-015 SHALL hold each of STATUS, MARK, FLOOR for exactly DWELL cycles, then advance STATUS -> MARK -> FLOOR -> STATUS cyclically.
REQ-016 SHALL use a frame counter 0..DWELL-1, width $clog2(DWELL), cleared on every state entry; advance when counter equals DWELL-1.
REQ-017 SHALL, when the status code differs from the previous cycle's status code, enter STATUS and clear the counter on the next edge, regardless of current state or count.
REQ-018 SHALL, in FLOOR, track registered FLOOR changes cycle-by-cycle without restarting the frame.
REQ-019 SHALL drive code 0 in FLOOR state when registered FLOOR is 0 or 5..7.
REQ-020 SHALL enter TEST from any state while registered LAMP_TEST is 1, hold it with counter frozen at 0, and on release enter STATUS with counter cleared.
REQ-021 SHALL give LAMP_TEST priority over status change when both occur in the same cycle.
REQ-022 SHALL pulse FRAME_START for one cycle coincident with the first BCD value of each STATUS, MARK or FLOOR entry, including restarts per REQ-017/020; never in TEST.

Reset
REQ-023 SHALL, while RST_N is 0, force state STATUS, counter 0, all input registers 0, previous status 0, BCD 0, FRAME_START 0.
REQ-024 SHALL, on RST_N deassertion, begin a full STATUS frame of DWELL cycles; reset mid-frame SHALL discard all progress.

Structure
REQ-025 SHALL place BCD code constants (0..9), status encoding and the FSM state enum in shared package ascensor_pkg.
REQ-026 SHALL implement the frame counter as sub-module dwell_timer (inputs clear, enable; output done), parameterised by DWELL.

Verification (DWELL=4)
REQ-027 SHALL check: reset release, FLOOR=2, all else 0 -> BCD 0,0,0,0,9,9,9,9,2,2,2,2 repeating; FRAME_START every 4 cycles.
REQ-028 SHALL check: MOTION 00->01 during MARK frame -> BCD 5 two edges later for 4 cycles, FRAME_START pulse, then 9.
REQ-029 SHALL check: DOOR_OPEN=1 with MOTION=10 -> status code 6, not 8; DOOR_OPEN drop -> restart showing 8.
REQ-030 SHALL check: FLOOR 3->4 in cycle 2 of FLOOR frame -> BCD 3 then 4 within frame, frame still ends after 4 cycles total.
REQ-031 SHALL check: LAMP_TEST pulse of 6 cycles mid-FLOOR -> BCD 8 for 6 cycles, no FRAME_START, then full STATUS frame; FLOOR=6 -> FLOOR frame shows 0.
REQ-032 SHALL check: RST_N asserted mid-MARK frame, asynchronous to CLK -> BCD 0 immediately, no codes above 9 ever observed.
